// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// CHECK is only reachable when INST_MEM_LOADER_CHECKSUM_EN is defined.
package inst_mem_loader_pkg;

    localparam int unsigned MEM_DEPTH      = 2048;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Requested word count limited to the program-memory depth.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : n;
    endfunction

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Big-endian byte-to-word shift register with a 2-bit byte counter.
// full flags the shift that completes the current word.
module byte_packer
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              full
);

    logic [DATA_W-1:0] r_word;
    logic [1:0]        r_cnt;

    assign word = r_word;
    assign full = shift_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_cnt  <= '0;
        end else if (shift_en) begin
            r_word <= {r_word[DATA_W-9:0], byte_in};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams bytes from a serial receiver into program memory, holding the CPU via busy.
// Optional trailing XOR checksum byte enabled by INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [11:0]       num_words,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              checksum_err
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              w_accept;
    logic              w_clear;
    logic              w_shift;
    logic              w_full;
    logic              w_last;
    logic [DATA_W-1:0] w_word;

    assign rx_ready = (r_state == RECV) || (r_state == CHECK);
    assign w_accept = rx_valid && rx_ready;
    assign w_shift  = w_accept && (r_state == RECV);
    assign w_clear  = ((r_state == IDLE) && start) || (r_state == WRITE);
    assign w_last   = (CNT_W'(r_idx) == (r_count - CNT_W'(1)));

    assign wr_en   = r_wr_en;
    assign wr_addr = r_idx;
    assign wr_data = w_word;
    assign busy    = r_busy;
    assign done    = r_done;

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_clear),
        .shift_en (w_shift),
        .byte_in  (rx_data),
        .word     (w_word),
        .full     (w_full)
    );

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_cerr;
    assign checksum_err = r_cerr;
`else
    assign checksum_err = 1'b0;
`endif

    // Loader FSM; strobes are single-cycle and cleared by default each cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_count <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
            r_cerr  <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= clamp_count(num_words);
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
                        r_cerr  <= 1'b0;
`endif
                        if (num_words == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RECV;
                        end
                    end
                end
                RECV: begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                    if (w_accept) r_csum <= r_csum ^ rx_data;
`endif
                    if (w_full) begin
                        r_state <= WRITE;
                        r_wr_en <= 1'b1;
                    end
                end
                WRITE: begin
                    if (w_last) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                        r_state <= CHECK;
`else
                        r_state <= DONE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_idx   <= r_idx + ADDR_W'(1);
                        r_state <= RECV;
                    end
                end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_accept) begin
                        r_cerr  <= (rx_data != r_csum);
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: stimulus queues expected writes, a monitor checks them.
// Checksum expectations follow INST_MEM_LOADER_CHECKSUM_EN.
module tb_inst_mem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [11:0] num_words;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        checksum_err;

    int          total = 0;
    int          bad   = 0;
    logic [42:0] exp_q[$];
    logic [31:0] preset[$];
    logic [42:0] e;
    int          wr_count = 0;
    int          last_addr = -1;
    bit          rdy_seen = 0;

    inst_mem_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_words    (num_words),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .checksum_err (checksum_err)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (rx_ready) rdy_seen = 1;
        if (wr_en) begin
            wr_count++;
            last_addr = int'(wr_addr);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    bad++;
                    $display("FAIL write actual=%0d:%h required=%0d:%h",
                             wr_addr, wr_data, e[42:32], e[31:0]);
                end
            end
        end
    end

    // Present one byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                rx_valid = 0;
                rx_data  = 8'($urandom);
                @(posedge clock); #1;
            end
        end
        rx_data  = b;
        rx_valid = 1;
        while (!rx_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!rx_ready) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(posedge clock); #1;
        if (rnd) rx_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbytes, input bit rnd);
        for (int b = 3; b >= 4 - nbytes; b--) send_byte(w[b*8 +: 8], rnd);
    endtask

    task automatic pulse_start(input logic [11:0] n);
        start = 1;
        num_words = n;
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic run_load(input logic [11:0] n, input bit rnd, input bit bad_ck);
        int unsigned cnt;
        logic [7:0]  x;
        logic [31:0] w;
        int          guard;
        bit          exp_err;
        cnt = (n > 12'd2048) ? 2048 : int'(n);
        x = 8'h00;
        exp_err = 0;
        rdy_seen = 0;
        pulse_start(n);
        if (cnt == 0) begin
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_busy", 64'(busy), 64'd1);
        end else begin
            chk("busy_during", 64'(busy), 64'd1);
            for (int i = 0; i < int'(cnt); i++) begin
                w = (preset.size() > 0) ? preset.pop_front() : $urandom;
                exp_q.push_back({11'(i), w});
                send_word(w, 4, rnd);
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                chk("wr_latency", 64'(wr_en), 64'd1);
            end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            send_byte(x ^ 8'(bad_ck), rnd);
            exp_err = bad_ck;
`endif
            rx_valid = 0;
            guard = 0;
            while (!done && guard < 20) begin
                @(posedge clock); #1;
                guard++;
            end
            chk("done_seen", 64'(done), 64'd1);
        end
        @(posedge clock); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        chk("checksum_err", 64'(checksum_err), 64'(exp_err));
        if (cnt == 0) chk("zero_no_ready", 64'(rdy_seen), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        reset = 1; start = 0; num_words = '0; rx_data = '0; rx_valid = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cerr", 64'(checksum_err), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);

        // Two known words, rx_valid held high.
        preset.push_back(32'h00011821);
        preset.push_back(32'hDEADBEEF);
        run_load(12'd2, 0, 0);

        // One word with random rx_valid gaps.
        preset.push_back(32'h12345678);
        run_load(12'd1, 1, 0);

        // Zero-length load.
        wc0 = wr_count;
        run_load(12'd0, 0, 0);
        chk("zero_writes", 64'(wr_count - wc0), 64'd0);

        // Checksum good then bad.
        preset.push_back(32'h01020304);
        run_load(12'd1, 0, 0);
        preset.push_back(32'h01020304);
        run_load(12'd1, 0, 1);

        // Reset in the middle of word 3.
        pulse_start(12'd5);
        for (int i = 0; i < 3; i++) begin
            e = {11'(i), 32'($urandom)};
            exp_q.push_back(e);
            send_word(e[31:0], 4, 1);
        end
        send_word(32'hCAFEF00D, 2, 1);
        rx_valid = 0;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rx_ready", 64'(rx_ready), 64'd0);
        chk("abort_wr_addr", 64'(wr_addr), 64'd0);
        chk("abort_wr_data", 64'(wr_data), 64'd0);
        repeat (5) @(posedge clock);
        #1;
        chk("abort_writes", 64'(exp_q.size()), 64'd0);
        run_load(12'd1, 1, 0);

        // Reset wins over start.
        reset = 1; start = 1; num_words = 12'd3;
        @(posedge clock); #1;
        reset = 0; start = 0;
        chk("rst_prio_busy", 64'(busy), 64'd0);
        @(posedge clock); #1;
        chk("rst_prio_idle", 64'(rx_ready), 64'd0);

        // Random loads.
        for (int k = 0; k < 6; k++)
            run_load(12'($urandom_range(1, 6)), 1, bit'($urandom_range(0, 1)));

        // Oversized request clamps to memory depth.
        wc0 = wr_count;
        run_load(12'd4095, 0, 0);
        chk("clamp_writes", 64'(wr_count - wc0), 64'd2048);
        chk("clamp_last_addr", 64'(last_addr), 64'd2047);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the word-address width (2048-word program memory).
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width; only 32 is supported.
REQ-003 Port clock, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle load request; it SHALL be ignored unless the state is IDLE.
REQ-006 Port num_words, input, 12: word count, sampled only on an accepted start.
REQ-007 Port rx_data, input, 8: byte stream, first byte received = bits [31:24] (big-endian).
REQ-008 Port rx_valid, input, 1: rx_data is valid this cycle.
REQ-009 Port rx_ready, output, 1: loader can accept a byte this cycle.
REQ-010 Port wr_en, output, 1: program-memory write strobe.
REQ-011 Port wr_addr, output, ADDR_W: word write address.
REQ-012 Port wr_data, output, DATA_W: assembled instruction word.
REQ-013 Port busy, output, 1: load in progress, used to hold the CPU and its PC.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port checksum_err, output, 1: checksum mismatch flag (see Configuration).

Function
REQ-016 States SHALL be IDLE, RECV, WRITE, CHECK and DONE.
REQ-017 IDLE + start: latch count = min(num_words, 2048), clear word index and byte count, go to RECV; if count is 0, go to DONE instead.
REQ-018 A byte SHALL be accepted only when rx_valid && rx_ready.
REQ-019 rx_ready SHALL be 1 only in RECV and CHECK, and SHALL be combinational from state.
REQ-020 RECV: each accepted byte shifts into the word register; the 4th accepted byte SHALL move the FSM to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with wr_en=1, wr_addr=word index and wr_data=assembled word.
REQ-022 wr_en SHALL be 0 in every state other than WRITE.
REQ-023 After WRITE: if the word index = count-1, go to CHECK (macro defined) or DONE (macro undefined); otherwise increment the index, clear the byte count and return to RECV.
REQ-024 The word index SHALL never exceed 2047, so wr_addr never wraps.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 rx_valid while rx_ready=0 SHALL be ignored; the byte is not consumed.
REQ-028 Latency: the 4th byte accepted in cycle N SHALL produce wr_en in cycle N+1; the next byte can be accepted in cycle N+2.

Reset
REQ-029 Reset SHALL force state IDLE, clear the index, byte count, word register and checksum, and drive rx_ready=wr_en=busy=done=checksum_err=0, wr_addr=0 and wr_data=0.
REQ-030 Reset mid-load SHALL discard any partial word and issue no further writes; words already written SHALL stay in memory.
REQ-031 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 With macro INST_MEM_LOADER_CHECKSUM_EN defined, the loader SHALL keep a running XOR of all data bytes.
REQ-033 With the macro defined, CHECK SHALL accept one further byte, set checksum_err = (byte != running XOR), and go to DONE.
REQ-034 With the macro defined, checksum_err SHALL hold until the next accepted start or reset; a count of 0 SHALL skip CHECK.
REQ-035 With the macro undefined, the CHECK state and XOR logic SHALL be absent and checksum_err SHALL be tied to 0.

Structure
REQ-036 A shared package SHALL hold the state enum, the MEM_DEPTH=2048 constant, and the BYTES_PER_WORD=4 constant.
REQ-037 Byte-to-word assembly SHALL be a sub-module byte_packer (shift register plus 2-bit byte counter, with full and clear signals); the FSM SHALL stay in inst_mem_loader.

Verification
REQ-038 start with num_words=2, bytes 00 01 18 21 DE AD BE EF streamed with rx_valid held high -> wr_en at addr 0 with data 0x00011821, wr_en at addr 1 with data 0xDEADBEEF, done pulse, busy low after done.
REQ-039 rx_valid toggled randomly during a 1-word load of 0x12345678 -> exactly one write of 0x12345678 at addr 0; no byte lost or duplicated.
REQ-040 start with num_words=0 -> done pulse 1 cycle after start, no wr_en, and rx_ready never asserted.
REQ-041 Reset asserted after 2 bytes of word 3 -> no wr_en at addr 3, state IDLE; a new start with num_words=1 writes addr 0.
REQ-042 (macro defined) 1 word 0x01020304, then checksum byte 0x04 -> checksum_err=0; repeating with checksum byte 0x05 -> checksum_err=1.
REQ-043 num_words=4095 -> load clamped to 2048 words; last write at addr 2047, then done.
